// File: rtl/wb_bq_coeff_loader.sv
// wb_bq_coeff_loader: queued Wishbone classic initiator for the biquad/AGC
// coefficient target ports. Requests are buffered in a small FIFO and issued
// one at a time, with retry and timeout handling and one response each.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no cycle on the bus; pop a request, then issue it next edge
// ST_ACTIVE | cyc/stb asserted, waiting for err/ack/rty or timeout
// ST_GAP    | one cycle with cyc low; reissue on pending retry, else idle
module wb_bq_coeff_loader #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [21:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    output logic        wb_m_cyc_o,
    output logic        wb_m_stb_o,
    output logic        wb_m_we_o,
    output logic [21:0] wb_m_adr_o,
    output logic [31:0] wb_m_dat_o,
    output logic [3:0]  wb_m_sel_o,
    input  logic [31:0] wb_m_dat_i,
    input  logic        wb_m_ack_i,
    input  logic        wb_m_err_i,
    input  logic        wb_m_rty_i,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic [31:0] rsp_dat_o,
    output logic        busy_o
);

    localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int EW = 1 + 22 + 32;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_SAT  = '1;
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // ---------------- request FIFO ----------------
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic [EW-1:0] head;

    assign req_ready_o = (count_q != FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign push        = req_valid_i & req_ready_o;
    assign head        = fifo_mem[rd_ptr_q];

    // Entry storage; contents are only ever read behind a non-zero count.
    always_ff @(posedge wb_clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= {req_we_i, req_adr_i, req_dat_i};
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    state_t        state_q;
    state_t        state_d;
    logic          loaded_q;
    logic          retry_pend_q;
    logic [RW-1:0] rty_cnt_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          we_q;
    logic [21:0]   adr_q;
    logic [31:0]   dat_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic          rsp_tmo_q;
    logic [31:0]   rsp_dat_q;

    logic in_active;
    logic ev_err;
    logic ev_ack;
    logic ev_rty;
    logic ev_tmo;
    logic rty_exhausted;
    logic issue;
    logic reissue;
    logic rsp_fire;
    logic retry_take;
    logic tmo_tick;

    // Termination priority is err > ack > rty > timeout.
    assign in_active     = (state_q == ST_ACTIVE);
    assign ev_err        = in_active & wb_m_err_i;
    assign ev_ack        = in_active & ~wb_m_err_i & wb_m_ack_i;
    assign ev_rty        = in_active & ~wb_m_err_i & ~wb_m_ack_i & wb_m_rty_i;
    assign ev_tmo        = in_active & ~wb_m_err_i & ~wb_m_ack_i & ~wb_m_rty_i
                           & (tmo_cnt_q >= TMO_LAST);
    assign rty_exhausted = (rty_cnt_q >= RTY_MAX);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (loaded_q) state_d = ST_ACTIVE;
            ST_ACTIVE: if (ev_err | ev_ack | ev_rty | ev_tmo) state_d = ST_GAP;
            ST_GAP:    state_d = retry_pend_q ? ST_ACTIVE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes; a pop in GAP prefetches so requests run every 3 edges.
    always_comb begin
        pop        = 1'b0;
        issue      = 1'b0;
        reissue    = 1'b0;
        rsp_fire   = 1'b0;
        retry_take = 1'b0;
        tmo_tick   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue = loaded_q;
                pop   = ~loaded_q & ~fifo_empty;
            end
            ST_ACTIVE: begin
                rsp_fire   = ev_err | ev_ack | ev_tmo | (ev_rty & rty_exhausted);
                retry_take = ev_rty & ~rty_exhausted;
                tmo_tick   = ~(ev_err | ev_ack | ev_rty | ev_tmo);
            end
            ST_GAP: begin
                reissue = retry_pend_q;
                pop     = ~retry_pend_q & ~loaded_q & ~fifo_empty;
            end
            default: ;
        endcase
    end

    // Bus strobes decode straight from state so an async reset drops them at once.
    assign wb_m_cyc_o = in_active;
    assign wb_m_stb_o = in_active;
    assign wb_m_we_o  = in_active & we_q;
    assign wb_m_sel_o = {4{in_active}};
    assign wb_m_adr_o = adr_q;
    assign wb_m_dat_o = dat_q;

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_tmo_q;
    assign rsp_dat_o     = rsp_dat_q;
    assign busy_o        = ~fifo_empty | loaded_q | (state_q != ST_IDLE);

    // Request holding registers, retry/timeout counters and response registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            loaded_q     <= 1'b0;
            retry_pend_q <= 1'b0;
            rty_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_tmo_q    <= 1'b0;
            rsp_dat_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_fire;
            if (pop) begin
                {we_q, adr_q, dat_q} <= head;
                loaded_q             <= 1'b1;
            end
            if (issue) begin
                loaded_q  <= 1'b0;
                rty_cnt_q <= '0;
                tmo_cnt_q <= '0;
            end
            if (reissue) begin
                retry_pend_q <= 1'b0;
                tmo_cnt_q    <= '0;
            end
            if (tmo_tick && (tmo_cnt_q != TMO_SAT)) tmo_cnt_q <= tmo_cnt_q + TW'(1);
            if (retry_take) begin
                rty_cnt_q    <= rty_cnt_q + RW'(1);
                retry_pend_q <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_err_q <= ~ev_ack;
                rsp_tmo_q <= ev_tmo;
                if (ev_ack) rsp_dat_q <= we_q ? dat_q : wb_m_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_wb_bq_coeff_loader.sv
// Directed bench for wb_bq_coeff_loader with a scripted Wishbone target.
module tb_wb_bq_coeff_loader;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_RTY  = 2;
    localparam int K_NONE = 3;

    typedef struct {
        int          kind;
        int          dly;
        logic [31:0] dat;
    } plan_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [21:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic        req_ready;
    logic        cyc, stb, m_we;
    logic [21:0] m_adr;
    logic [31:0] m_dat;
    logic [3:0]  m_sel;
    logic [31:0] s_dat = '0;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic        rsp_valid, rsp_err, rsp_tmo;
    logic [31:0] rsp_dat;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;
    int last_push_edge = 0;

    wb_bq_coeff_loader #(.FIFO_DEPTH(8), .TIMEOUT(16), .MAX_RETRY(3)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_adr_i(req_adr), .req_dat_i(req_dat),
        .wb_m_cyc_o(cyc), .wb_m_stb_o(stb), .wb_m_we_o(m_we), .wb_m_adr_o(m_adr),
        .wb_m_dat_o(m_dat), .wb_m_sel_o(m_sel), .wb_m_dat_i(s_dat),
        .wb_m_ack_i(s_ack), .wb_m_err_i(s_err), .wb_m_rty_i(s_rty),
        .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_tmo),
        .rsp_dat_o(rsp_dat), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    // Scripted target: one plan entry per cyc assertion, default is ack with address-derived data.
    plan_t plan_q[$];
    plan_t cur;
    logic  t_prev = 1'b0;
    logic  tgt_hold = 1'b0;
    int    t_cnt = 0;
    always @(negedge clk) begin
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        if (cyc) begin
            if (!t_prev) begin
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else begin
                    cur.kind = K_ACK; cur.dly = 1;
                    cur.dat  = 32'h5A000000 | {10'h0, m_adr};
                end
                t_cnt = 0;
            end
            t_cnt++;
            if (!tgt_hold && t_cnt >= cur.dly) begin
                case (cur.kind)
                    K_ACK: begin s_ack = 1'b1; s_dat = cur.dat; end
                    K_ERR: s_err = 1'b1;
                    K_RTY: s_rty = 1'b1;
                    default: ;
                endcase
            end
        end
        t_prev = cyc;
    end

    // Bus and response monitor: records each cyc assertion and each response pulse.
    logic        m_prev = 1'b0;
    int          len_run = 0, gap_run = 0, g_start = 0, start_edge = 0;
    logic        we_run = 1'b0;
    logic [21:0] adr_run = '0;
    logic [31:0] dat_run = '0;
    int          a_len[$], a_gap[$], a_edge[$];
    logic        a_we[$];
    logic [21:0] a_adr[$];
    logic [31:0] a_dat[$];
    logic        r_err[$], r_tmo[$];
    logic [31:0] r_dat[$];
    int          sel_bad = 0, hold_bad = 0, rsp_pos_bad = 0;
    always @(negedge clk) begin
        if (cyc) begin
            if (!m_prev) begin
                adr_run = m_adr; dat_run = m_dat; we_run = 1'b0; len_run = 0;
                start_edge = edge_n; g_start = gap_run; gap_run = 0;
            end
            len_run++;
            we_run = we_run | m_we;
            if (m_sel != 4'hF || !stb) sel_bad++;
            if (m_adr != adr_run || m_dat != dat_run) hold_bad++;
        end else begin
            gap_run++;
            if (m_prev) begin
                a_len.push_back(len_run); a_gap.push_back(g_start); a_edge.push_back(start_edge);
                a_we.push_back(we_run); a_adr.push_back(adr_run); a_dat.push_back(dat_run);
            end
        end
        if (rsp_valid) begin
            r_err.push_back(rsp_err); r_tmo.push_back(rsp_tmo); r_dat.push_back(rsp_dat);
            if (!(m_prev && !cyc)) rsp_pos_bad++;
        end
        m_prev = cyc;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input logic we, input logic [21:0] adr, input logic [31:0] dat);
        int n = 0;
        req_we = we; req_adr = adr; req_dat = dat; req_valid = 1'b1;
        while (!req_ready && n < 200) begin step(); n++; end
        if (!req_ready) check_val("push_ready", req_ready, 1);
        step();
        last_push_edge = edge_n;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int k = 0;
        while ((r_dat.size() < n || busy) && k < 600) begin step(); k++; end
        check_val(tag, (r_dat.size() >= n) && !busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int ba, br, pe, rc;
        plan_t p;

        // Reset state
        repeat (3) step();
        check_val("rst_bus", {cyc, stb, m_we, m_sel, m_adr, m_dat}, 64'h0);
        check_val("rst_rsp", {rsp_valid, rsp_err, rsp_tmo, rsp_dat}, 64'h0);
        check_val("rst_busy", busy, 0);
        check_val("rst_ready", req_ready, 1);
        rst = 1'b0;
        step();

        // Write, target acks in the third stb cycle
        ba = a_len.size(); br = r_dat.size();
        p = '{K_ACK, 3, 32'h0}; plan_q.push_back(p);
        push_req(1'b1, 22'h000104, 32'hDEADBEEF);
        pe = last_push_edge;
        wait_rsp("t1_done", br + 1);
        check_val("t1_ncyc", a_len.size() - ba, 1);
        check_val("t1_len", a_len[ba], 3);
        check_val("t1_we", a_we[ba], 1);
        check_val("t1_adr", a_adr[ba], 22'h000104);
        check_val("t1_latency", a_edge[ba] - pe, 2);
        check_val("t1_err", r_err[br], 0);
        check_val("t1_dat", r_dat[br], 32'hDEADBEEF);
        check_val("t1_cyc_low", cyc, 0);

        // Read
        ba = a_len.size(); br = r_dat.size();
        p = '{K_ACK, 1, 32'h12345678}; plan_q.push_back(p);
        push_req(1'b0, 22'h000010, 32'h0);
        wait_rsp("t2_done", br + 1);
        check_val("t2_len", a_len[ba], 1);
        check_val("t2_we", a_we[ba], 0);
        check_val("t2_err", r_err[br], 0);
        check_val("t2_dat", r_dat[br], 32'h12345678);

        // Two retries then ack
        ba = a_len.size(); br = r_dat.size();
        p = '{K_RTY, 1, 32'h0}; plan_q.push_back(p); plan_q.push_back(p);
        p = '{K_ACK, 1, 32'h0}; plan_q.push_back(p);
        push_req(1'b1, 22'h000020, 32'hCAFEF00D);
        wait_rsp("t3_done", br + 1);
        check_val("t3_ncyc", a_len.size() - ba, 3);
        for (int i = 0; i < 3; i++) begin
            check_val("t3_adr", a_adr[ba + i], 22'h000020);
            check_val("t3_dat", a_dat[ba + i], 32'hCAFEF00D);
        end
        check_val("t3_gap1", a_gap[ba + 1] >= 1, 1);
        check_val("t3_gap2", a_gap[ba + 2] >= 1, 1);
        check_val("t3_nrsp", r_dat.size() - br, 1);
        check_val("t3_err", r_err[br], 0);
        check_val("t3_rdat", r_dat[br], 32'hCAFEF00D);

        // Four retries exhaust MAX_RETRY
        ba = a_len.size(); br = r_dat.size();
        p = '{K_RTY, 1, 32'h0};
        for (int i = 0; i < 4; i++) plan_q.push_back(p);
        push_req(1'b0, 22'h000030, 32'h0);
        wait_rsp("t3b_done", br + 1);
        check_val("t3b_ncyc", a_len.size() - ba, 4);
        check_val("t3b_nrsp", r_dat.size() - br, 1);
        check_val("t3b_err", r_err[br], 1);
        check_val("t3b_tmo", r_tmo[br], 0);

        // Timeout, then the queued request proceeds
        ba = a_len.size(); br = r_dat.size();
        p = '{K_NONE, 1, 32'h0}; plan_q.push_back(p);
        p = '{K_ACK, 1, 32'h0BADCAFE}; plan_q.push_back(p);
        push_req(1'b0, 22'h000040, 32'h0);
        push_req(1'b0, 22'h000044, 32'h0);
        wait_rsp("t4_done", br + 2);
        check_val("t4_len", a_len[ba], 16);
        check_val("t4_err0", r_err[br], 1);
        check_val("t4_tmo0", r_tmo[br], 1);
        check_val("t4_err1", r_err[br + 1], 0);
        check_val("t4_tmo1", r_tmo[br + 1], 0);
        check_val("t4_dat1", r_dat[br + 1], 32'h0BADCAFE);
        check_val("t4_adr1", a_adr[ba + 1], 22'h000044);
        check_val("t4_gap1", a_gap[ba + 1], 2);

        // Fill the FIFO behind a stalled cycle, then drain in order
        br = r_dat.size();
        tgt_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push_req(1'b0, 22'h000100 + 22'(i), 32'h0);
            if (i == 7) check_val("t5_ready7", req_ready, 1);
        end
        check_val("t5_full", req_ready, 0);
        check_val("t5_busy", busy, 1);
        tgt_hold = 1'b0;
        wait_rsp("t5_done", br + 9);
        check_val("t5_nrsp", r_dat.size() - br, 9);
        for (int i = 0; i < 9; i++) begin
            check_val("t5_dat", r_dat[br + i], 32'h5A000100 + 32'(i));
            check_val("t5_err", r_err[br + i], 0);
        end
        check_val("t5_idle", busy, 0);

        // Async reset during a cycle with requests queued
        tgt_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_req(1'b0, 22'h000200 + 22'(i), 32'h0);
        check_val("t6_pre_cyc", cyc, 1);
        rc = r_dat.size();
        #1 rst = 1'b1;
        #1;
        check_val("t6_async_drop", {cyc, stb}, 0);
        step(); step();
        rst = 1'b0;
        tgt_hold = 1'b0;
        plan_q.delete();
        step();
        check_val("t6_ready", req_ready, 1);
        check_val("t6_busy", busy, 0);
        check_val("t6_no_rsp", r_dat.size(), rc);
        p = '{K_ACK, 2, 32'h600DF00D}; plan_q.push_back(p);
        push_req(1'b0, 22'h00003F, 32'h0);
        wait_rsp("t6_done", rc + 1);
        check_val("t6_nrsp", r_dat.size() - rc, 1);
        check_val("t6_dat", r_dat[rc], 32'h600DF00D);
        check_val("t6_err", r_err[rc], 0);

        // Whole-run bus invariants
        check_val("sel_stb_ok", sel_bad, 0);
        check_val("adr_dat_stable", hold_bad, 0);
        check_val("rsp_on_cyc_drop", rsp_pos_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
